// File: rtl/issue_scheduler_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : issue_scheduler_pkg
// Brief   : Shared unit, width and FSM encodings for the issue scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package issue_scheduler_pkg;

  localparam int ROW_W      = 5;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_MEM = 2'd2;
  localparam logic [1:0] UNIT_DIV = 2'd3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/issue_scheduler_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : issue_scheduler_if
// Brief   : Decode, scoreboard, issue and drain signals of the issue scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface issue_scheduler_if
  import issue_scheduler_pkg::*;
#(
  parameter int ROW_W   = 5,
  parameter int STALL_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rs;
  logic [REG_ADDR_W-1:0] in_rt;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_uses_rs;
  logic                  in_uses_rt;
  logic                  in_writes;
  logic [1:0]            in_unit;

  logic [REG_ADDR_W-1:0] sb_addr_a;
  logic [REG_ADDR_W-1:0] sb_addr_b;
  logic                  sb_pending_a;
  logic                  sb_pending_b;
  logic [1:0]            sb_unit_a;
  logic [1:0]            sb_unit_b;
  logic [ROW_W-1:0]      sb_row_a;
  logic [ROW_W-1:0]      sb_row_b;
  logic [REG_ADDR_W-1:0] sb_addr_d;
  logic                  sb_pending_d;
  logic [REG_ADDR_W-1:0] sb_writeaddr;
  logic [1:0]            sb_registerunit;
  logic                  sb_enablewrite;

  logic                  iss_valid;
  logic [1:0]            iss_unit;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic                  iss_fwd_a;
  logic                  iss_fwd_b;

  logic                  drain_req;
  logic                  drained;
  logic [STALL_W-1:0]    stall_count;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_uses_rs, in_uses_rt, in_writes, in_unit,
    output sb_pending_a, sb_pending_b, sb_unit_a, sb_unit_b, sb_row_a, sb_row_b,
    output sb_pending_d, drain_req,
    input  in_ready, sb_addr_a, sb_addr_b, sb_addr_d, sb_writeaddr, sb_registerunit,
    input  sb_enablewrite, iss_valid, iss_unit, iss_rd, iss_fwd_a, iss_fwd_b,
    input  drained, stall_count
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_uses_rs, in_uses_rt, in_writes, in_unit,
    input  sb_pending_a, sb_pending_b, sb_unit_a, sb_unit_b, sb_row_a, sb_row_b,
    input  sb_pending_d, drain_req,
    output in_ready, sb_addr_a, sb_addr_b, sb_addr_d, sb_writeaddr, sb_registerunit,
    output sb_enablewrite, iss_valid, iss_unit, iss_rd, iss_fwd_a, iss_fwd_b,
    output drained, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/issue_scheduler_wb_reservation.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : wb_reservation
// Brief   : Writeback-port reservation shift vector, latency decode and conflict check.
// Revision: 1.0 - initial release
// ============================================================================
module wb_reservation
  import issue_scheduler_pkg::*;
#(
  parameter int ROW_W  = 5,
  parameter int LAT_U0 = 1,
  parameter int LAT_U1 = 3,
  parameter int LAT_U2 = 2,
  parameter int LAT_U3 = 5
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       unit,
  input  logic             writes,
  input  logic             claim,
  output logic             conflict,
  output logic [ROW_W-1:0] wb_res
);
  logic [ROW_W-1:0] r_wb_res;
  logic [ROW_W-1:0] w_shifted;
  logic [ROW_W-1:0] w_slot;

  always_comb begin
    w_slot = '0;
    case (unit)
      UNIT_ALU: w_slot = ROW_W'(1) << (LAT_U0 - 1);
      UNIT_MUL: w_slot = ROW_W'(1) << (LAT_U1 - 1);
      UNIT_MEM: w_slot = ROW_W'(1) << (LAT_U2 - 1);
      default:  w_slot = ROW_W'(1) << (LAT_U3 - 1);
    endcase
  end

  // Checking against the shifted vector means a new claim can never land on a bit being vacated.
  assign w_shifted = r_wb_res >> 1;
  assign conflict  = writes & (|(w_shifted & w_slot));
  assign wb_res    = r_wb_res;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_res <= '0;
    end else begin
      r_wb_res <= w_shifted | (claim ? w_slot : '0);
    end
  end
endmodule
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : issue_scheduler
// Brief   : In-order issue with RAW/WAW/writeback hazard checks and a drain sequence.
//           Operand bypass on ready-next results enabled by ISSUE_SCHEDULER_FORWARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module issue_scheduler
#(
  parameter int ROW_W   = 5,
  parameter int LAT_U0  = 1,
  parameter int LAT_U1  = 3,
  parameter int LAT_U2  = 2,
  parameter int LAT_U3  = 5,
  parameter int STALL_W = 16
)(
  input  logic             clock,
  input  logic             reset,
  issue_scheduler_if.slave bus
);
  import issue_scheduler_pkg::*;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_drained;
  logic [ROW_W-1:0]      w_wb_res;
  logic                  w_struct;
  logic                  w_raw_a, w_raw_b;
  logic                  w_next_a, w_next_b;
  logic                  w_next_stall;
  logic                  w_fwd_a, w_fwd_b;
  logic                  w_waw;
  logic                  w_hazard;
  logic                  w_ready;
  logic                  w_fire;
  logic                  w_claim;
  logic                  w_unused;

  logic                  r_iss_valid;
  logic [1:0]            r_iss_unit;
  logic [REG_ADDR_W-1:0] r_iss_rd;
  logic                  r_iss_fwd_a;
  logic                  r_iss_fwd_b;
  logic [STALL_W-1:0]    r_stall_count;

  // Producing unit is informational only; hazard decisions use pending and row alone.
  assign w_unused = ^{bus.sb_unit_a, bus.sb_unit_b};

  assign w_raw_a  = bus.in_uses_rs & bus.sb_pending_a & (|bus.sb_row_a[ROW_W-1:1]);
  assign w_raw_b  = bus.in_uses_rt & bus.sb_pending_b & (|bus.sb_row_b[ROW_W-1:1]);
  assign w_next_a = bus.in_uses_rs & bus.sb_pending_a & (bus.sb_row_a == ROW_W'(1));
  assign w_next_b = bus.in_uses_rt & bus.sb_pending_b & (bus.sb_row_b == ROW_W'(1));

`ifdef ISSUE_SCHEDULER_FORWARD_EN
  assign w_next_stall = 1'b0;
  assign w_fwd_a      = w_next_a;
  assign w_fwd_b      = w_next_b;
`else
  assign w_next_stall = w_next_a | w_next_b;
  assign w_fwd_a      = 1'b0;
  assign w_fwd_b      = 1'b0;
`endif

  assign w_waw    = bus.in_writes & bus.sb_pending_d;
  assign w_hazard = w_raw_a | w_raw_b | w_next_stall | w_waw | w_struct;
  assign w_ready  = (r_state == RUN) & ~w_hazard;
  assign w_fire   = bus.in_valid & w_ready;
  // r0 is hard-wired, so it is never tracked in the scoreboard nor on the writeback port.
  assign w_claim  = w_fire & bus.in_writes & (bus.in_rd != '0);

  wb_reservation #(
    .ROW_W  (ROW_W),
    .LAT_U0 (LAT_U0),
    .LAT_U1 (LAT_U1),
    .LAT_U2 (LAT_U2),
    .LAT_U3 (LAT_U3)
  ) u_wb (
    .clock    (clock),
    .reset    (reset),
    .unit     (bus.in_unit),
    .writes   (bus.in_writes),
    .claim    (w_claim),
    .conflict (w_struct),
    .wb_res   (w_wb_res)
  );

  assign bus.in_ready        = w_ready;
  assign bus.sb_addr_a       = bus.in_rs;
  assign bus.sb_addr_b       = bus.in_rt;
  assign bus.sb_addr_d       = bus.in_rd;
  assign bus.sb_writeaddr    = bus.in_rd;
  assign bus.sb_registerunit = bus.in_unit;
  assign bus.sb_enablewrite  = w_claim;
  assign bus.iss_valid       = r_iss_valid;
  assign bus.iss_unit        = r_iss_unit;
  assign bus.iss_rd          = r_iss_rd;
  assign bus.iss_fwd_a       = r_iss_fwd_a;
  assign bus.iss_fwd_b       = r_iss_fwd_b;
  assign bus.drained         = w_drained;
  assign bus.stall_count     = r_stall_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_iss_valid <= 1'b0;
      r_iss_unit  <= '0;
      r_iss_rd    <= '0;
      r_iss_fwd_a <= 1'b0;
      r_iss_fwd_b <= 1'b0;
    end else begin
      r_iss_valid <= w_fire;
      if (w_fire) begin
        r_iss_unit  <= bus.in_unit;
        r_iss_rd    <= bus.in_rd;
        r_iss_fwd_a <= w_fwd_a;
        r_iss_fwd_b <= w_fwd_b;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (bus.in_valid && !w_ready && (r_state == RUN) && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_drained    = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.drain_req) w_next_state = DRAIN;
      end
      DRAIN: begin
        if ((w_wb_res == '0) && !r_iss_valid) w_next_state = DONE;
      end
      DONE: begin
        w_drained = 1'b1;
        if (!bus.drain_req) w_next_state = RUN;
      end
      default: w_next_state = RUN;
    endcase
  end
endmodule
`default_nettype wire

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- In-order issue controller sitting between decode and the functional units.
- Queries the register scoreboard for source operands and detects RAW hazards, WAW hazards, and structural hazards on the single shared writeback port.
- When an instruction is hazard-free, it claims the destination register in the scoreboard and issues the instruction to its functional unit.
- Provides a drain sequence so the pipeline can be emptied before exceptions or mode changes.

Parameters:
- ROW_W, 5, width of the scoreboard row field and of the writeback reservation vector.
- LAT_U0, 1, latency in cycles of unit 0 (ALU), range 1..ROW_W.
- LAT_U1, 3, latency of unit 1 (MUL).
- LAT_U2, 2, latency of unit 2 (MEM).
- LAT_U3, 5, latency of unit 3 (DIV).
- STALL_W, 16, width of the stall counter.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  scheduler accepts the instruction this cycle.
- in_rs, in_rt, in_rd  in  5 each  source and destination register addresses.
- in_uses_rs, in_uses_rt, in_writes  in  1 each  operand and destination usage flags.
- in_unit  in  2  target functional unit.
- sb_addr_a, sb_addr_b  out  5 each  scoreboard query addresses; equal in_rs and in_rt.
- sb_pending_a, sb_pending_b  in  1 each  scoreboard pending bits.
- sb_unit_a, sb_unit_b  in  2 each  producing unit.
- sb_row_a, sb_row_b  in  ROW_W each  one-hot result position.
- sb_addr_d  out  5  query address for in_rd; sb_pending_d  in  1.
- sb_writeaddr  out  5  register to mark pending.
- sb_registerunit  out  2  unit for that register.
- sb_enablewrite  out  1  claim strobe.
- iss_valid  out  1  issued instruction present.
- iss_unit  out  2; iss_rd  out  5.
- iss_fwd_a, iss_fwd_b  out  1 each  operand must be bypassed.
- drain_req  in  1  request to stop issuing and empty the pipeline.
- drained  out  1  pipeline empty while draining.
- stall_count  out  STALL_W  saturating count of stalled cycles.

Behaviour:
- Reset values: iss_valid, iss_unit, iss_rd, iss_fwd_* = 0; reservation vector wb_res = 0; state = RUN; drained = 0; stall_count = 0.
- Latency L is selected from in_unit via LAT_Ux.
- Hazard terms (combinational):
  - RAW on an operand: used and pending and row[ROW_W-1:1] != 0.
  - Ready-next operand: used, pending, row == 1. Stalls unless FORWARD_EN is defined.
  - WAW: in_writes and sb_pending_d.
  - Structural: in_writes and wb_res[L-1] set after this cycle's shift.
- in_ready = (state == RUN) and no hazard.
- Fire = in_valid & in_ready.
  - On fire with in_writes, assert the same cycle: sb_enablewrite = 1, sb_writeaddr = in_rd, sb_registerunit = in_unit.
  - in_rd == 0 never claims the scoreboard and never reserves a slot.
- Every cycle wb_res <= (wb_res >> 1) | (fire & in_writes ? 1 << (L-1) : 0).
- Issue outputs are registered, one-cycle latency. On fire they load iss_valid = 1, iss_unit, iss_rd, iss_fwd_*; otherwise iss_valid = 0.
- stall_count increments, saturating at all-ones, on each cycle where in_valid & !in_ready & state == RUN.
- FSM:
  - RUN: drain_req -> DRAIN. Fire is still permitted in the cycle drain_req rises.
  - DRAIN: in_ready = 0. When wb_res == 0 and iss_valid == 0, go to DONE.
  - DONE: drained = 1. When drain_req is deasserted, go to RUN with drained = 0 one cycle later.
- Boundaries:
  - A reservation at bit 0 expires on the next edge.
  - A simultaneous shift and new reservation at the same bit is impossible by construction, because the structural check is done post-shift.
  - Reset mid-DRAIN returns to RUN with wb_res cleared.
  - in_uses_x = 0 ignores all scoreboard fields for that operand.

Optional Feature:
- Macro: ISSUE_SCHEDULER_FORWARD_EN.
- When defined: an operand with row == 1 does not stall; the corresponding iss_fwd_x is set to 1.
- When undefined: that operand stalls one extra cycle; iss_fwd_a and iss_fwd_b are tied to 0.

Decomposition:
- Shared package holds:
  - unit encodings UNIT_ALU = 0, UNIT_MUL = 1, UNIT_MEM = 2, UNIT_DIV = 3;
  - ROW_W and REG_ADDR_W = 5;
  - FSM state encodings RUN, DRAIN, DONE.
- One natural sub-module: wb_reservation, which holds the shift vector, the conflict check, and the latency decode.

Test Plan:
- Independent ALU ops back-to-back, scoreboard all clear -> in_ready = 1 every cycle; iss_valid pulses one cycle after each fire; sb_enablewrite is asserted with each fire.
- rs = r3, with r3 pending, unit 1, row = 5'b00100 -> stall 2 cycles while stall_count increments by 2. Issue with row == 1: with FORWARD_EN, iss_fwd_a = 1; without it, one more stall cycle.
- MUL fire (L = 3), then ALU at +2 cycles (L = 1) -> structural conflict. The ALU waits one cycle; wb_res never shows two claims on the same bit.
- in_rd = r7 with sb_pending_d = 1 -> in_ready = 0 until pending clears; then fire with sb_writeaddr = 7.
- DIV fire, then drain_req held -> in_ready = 0; drained = 1 exactly after wb_res reaches 0 (5 cycles); deassert drain_req -> RUN.
- reset asserted during DRAIN with wb_res = 5'b01010 -> next cycle: state RUN, wb_res = 0, iss_valid = 0, stall_count = 0.
